icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, parametrised instruction cache between the fetch stage and the instruction backing memory. It replaces the flat preloaded instruction store with a tag/valid-checked line store. Misses refill a whole line over a valid/ready memory port, and a flush input invalidates all lines. A hit returns a 32-bit big-endian instruction word one cycle after the request is accepted.

## Interface
- `ADDR_W`, 32: byte address width.
- `LINES`, 64: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cpu_req_valid` in 1: fetch request.
- `cpu_req_addr` in `ADDR_W`: byte address of the instruction.
- `cpu_req_ready` out 1: request accepted on `valid && ready` at a rising edge.
- `cpu_resp_valid` out 1: one-cycle response pulse; there is no back-pressure.
- `cpu_resp_data` out 32: instruction word; 0 when `cpu_resp_err`.
- `cpu_resp_err` out 1: misaligned address (`addr[1:0] != 0`); qualified by `cpu_resp_valid`.
- `flush` in 1: invalidate all lines.
- `mem_req_valid` out 1: line refill request.
- `mem_req_addr` out `ADDR_W`: line-aligned byte address.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: refill beat valid.
- `mem_resp_data` in 32: refill beat, words delivered in ascending order starting at word 0.

## Operation
- Address split: `addr[1:0]` is the byte offset. `addr[OFF_W+1:2]` is the word, with `OFF_W = log2(WORDS_PER_LINE)`. The next `log2(LINES)` bits are the index. The remaining upper bits are the tag.
- States:
  - IDLE: nothing pending; `cpu_req_ready=1`.
  - LOOKUP: the accepted request is compared against tag/valid.
  - REFILL_REQ: `mem_req_valid=1`.
  - REFILL_DATA: collecting beats.
  - DONE: miss response cycle.
- IDLE → LOOKUP on acceptance.
- LOOKUP, hit: `cpu_resp_valid=1` with data. `cpu_req_ready=1`, so a new request is accepted in the same cycle and the state stays in LOOKUP; otherwise it goes to IDLE.
- LOOKUP, misaligned: `cpu_resp_valid=1`, `cpu_resp_err=1`, data 0. There is no refill, and ready/next state are the same as for a hit.
- LOOKUP, miss: `cpu_req_ready=0` and the state goes to REFILL_REQ.
- REFILL_REQ: `mem_req_addr` is the request address with the low `OFF_W+2` bits cleared. It is held stable until `mem_req_ready`, then the state goes to REFILL_DATA.
- REFILL_DATA:
  - Each `mem_resp_valid` beat writes the data array at `{index, beat_count}`.
  - The beat whose count equals the requested word is captured into the response register.
  - After beat `WORDS_PER_LINE-1`, the tag is written, the valid bit is set unless a flush occurred during this refill, and the state goes to DONE.
- DONE: `cpu_resp_valid=1` with the captured word and `cpu_req_ready=1`. Acceptance goes to LOOKUP, otherwise IDLE.
- Flush:
  - All valid bits clear at the edge on which `flush=1`.
  - In IDLE or LOOKUP, flush takes priority over the hit check. A LOOKUP in that cycle is treated as a miss.
  - During REFILL_REQ/REFILL_DATA the refill completes and its word is returned, but the line is left invalid.
- Stray `mem_resp_valid` outside REFILL_DATA is ignored.
- A conflict-miss refill overwrites the resident line; there is no write-back.

## Timing
- Reset values: state IDLE, all valid bits 0, `cpu_resp_valid=0`, `cpu_resp_err=0`, `cpu_resp_data=0`, `mem_req_valid=0`, `mem_req_addr=0`.
- `cpu_req_ready` is 0 during reset, then 1.
- Hit latency is 1 cycle after acceptance; hit throughput is 1 per cycle.
- Miss latency is (cycles to `mem_req_ready`) + `WORDS_PER_LINE` beats (gaps allowed) + 1. The response appears in the cycle after the last beat.
- Reset asserted mid-refill immediately drops `mem_req_valid`, returns the FSM to IDLE and invalidates all lines. No response is produced.
- The data array is a synchronous-read RAM indexed from `cpu_req_addr` at acceptance. Tags and valid bits are flops.

## Structure
- Package `icache_pkg`: state enum `icache_state_t`, and functions or localparams deriving `OFF_W`, `IDX_W` and `TAG_W` from the parameters.
- Sub-module `icache_data_ram`: `LINES*WORDS_PER_LINE` × 32 words, one synchronous read port and one write port, with write-first collision behaviour.
- Top level holds the FSM, tag/valid arrays, beat counter and response register.

## Test plan
All scenarios use `LINES=4`, `WORDS_PER_LINE=4`, with memory returning word = address.

1. **Cold miss then hit.** Request `0x80020008` → one `mem_req` at `0x80020000`. Beats `0x80020000`..`0x8002000C`; response `0x80020008` in the cycle after beat 3. Next request `0x8002000C` → response `0x8002000C` one cycle later, with no `mem_req`.
2. **Back-to-back hits.** `0x80020000`, `0x80020004`, `0x80020008` on consecutive cycles → three consecutive response pulses.
3. **Conflict eviction.** Request `0x80020000`, then `0x80020040` (same index, new tag) → refill; then `0x80020000` → a second refill at `0x80020000`.
4. **Misaligned.** Request `0x80020002` → `cpu_resp_err=1`, data 0, one cycle later, with no `mem_req`.
5. **Flush.** Flush asserted mid-refill of `0x80020010` → word still returned; re-request `0x80020010` → new refill. Flush after a filled line → the next access misses.
6. **Reset mid-refill.** Reset asserted after beat 1 of 4 → `mem_req_valid=0` and no response. Later beats are ignored. Request `0x80020000` after reset → fresh refill.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_REFILL_REQ  = 3'd2,
        ST_REFILL_DATA = 3'd3,
        ST_DONE        = 3'd4
    } icache_state_t;

    // Bits selecting a 32-bit word inside one line.
    function automatic int calcOffW(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    // Bits selecting one line of the cache.
    function automatic int calcIdxW(input int lines);
        return $clog2(lines);
    endfunction

    // Remaining upper address bits stored as the tag.
    function automatic int calcTagW(input int addrW, input int lines, input int wordsPerLine);
        return addrW - $clog2(lines) - $clog2(wordsPerLine) - 2;
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Word-wide line storage: one synchronous read port, one write port.
// A read that hits the address being written returns the new data.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          readEn_i,
    input  logic [AW-1:0] readAddr_i,
    output logic [31:0]   readData_o,
    input  logic          writeEn_i,
    input  logic [AW-1:0] writeAddr_i,
    input  logic [31:0]   writeData_i
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] readData_q;

    // Write port plus registered read port with write-first bypass on a collision.
    always_ff @(posedge clk_i) begin
        if (writeEn_i) begin
            mem_q[writeAddr_i] <= writeData_i;
        end
        if (readEn_i) begin
            readData_q <= (writeEn_i && (writeAddr_i == readAddr_i)) ? writeData_i
                                                                     : mem_q[readAddr_i];
        end
    end

    assign readData_o = readData_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: tag/valid flops, synchronous data RAM,
// whole-line refill over a valid/ready memory port, and a global flush.
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [31:0]       cpu_resp_data,
    output logic              cpu_resp_err,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int OFF_W  = calcOffW(WORDS_PER_LINE);
    localparam int IDX_W  = calcIdxW(LINES);
    localparam int TAG_W  = calcTagW(ADDR_W, LINES, WORDS_PER_LINE);
    localparam int RAM_AW = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    icache_state_t     state_q, state_d;
    logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [31:0]       resp_q, resp_d;
    logic              flushPend_q, flushPend_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [LINES-1:0]  valid_q;

    logic [OFF_W-1:0]  reqWord;
    logic [IDX_W-1:0]  reqIdx;
    logic [TAG_W-1:0]  reqTag;
    logic              misaligned;
    logic              lineHit;
    logic              tagWrite;
    logic              validSet;
    logic              ramReadEn;
    logic [RAM_AW-1:0] ramReadAddr;
    logic [31:0]       ramReadData;
    logic              ramWriteEn;
    logic [RAM_AW-1:0] ramWriteAddr;

    assign reqWord    = reqAddr_q[OFF_W+1:2];
    assign reqIdx     = reqAddr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign reqTag     = reqAddr_q[ADDR_W-1:OFF_W+IDX_W+2];
    assign misaligned = |reqAddr_q[1:0];
    // A flush in the lookup cycle wins over the tag match.
    assign lineHit    = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag) && !flush;

    assign mem_req_addr = {reqAddr_q[ADDR_W-1:OFF_W+2], (OFF_W+2)'(0)};

    // The RAM is read with the incoming address on the accepting edge.
    assign ramReadEn    = cpu_req_valid && cpu_req_ready;
    assign ramReadAddr  = cpu_req_addr[OFF_W+IDX_W+1:2];
    assign ramWriteAddr = {reqIdx, beat_q};

    icache_data_ram #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (RAM_AW)
    ) u_data_ram (
        .clk_i       (clock),
        .readEn_i    (ramReadEn),
        .readAddr_i  (ramReadAddr),
        .readData_o  (ramReadData),
        .writeEn_i   (ramWriteEn),
        .writeAddr_i (ramWriteAddr),
        .writeData_i (mem_resp_data)
    );

    // Next-state and output decode for the lookup/refill sequence.
    always_comb begin
        state_d        = state_q;
        reqAddr_d      = reqAddr_q;
        beat_d         = beat_q;
        resp_d         = resp_q;
        flushPend_d    = flushPend_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_err   = 1'b0;
        cpu_resp_data  = 32'd0;
        mem_req_valid  = 1'b0;
        ramWriteEn     = 1'b0;
        tagWrite       = 1'b0;
        validSet       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    reqAddr_d = cpu_req_addr;
                    state_d   = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (misaligned || lineHit) begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_err   = misaligned;
                    cpu_resp_data  = misaligned ? 32'd0 : ramReadData;
                    cpu_req_ready  = 1'b1;
                    if (cpu_req_valid) begin
                        reqAddr_d = cpu_req_addr;
                        state_d   = ST_LOOKUP;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    beat_d      = '0;
                    flushPend_d = 1'b0;
                    state_d     = ST_REFILL_REQ;
                end
            end

            ST_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                if (flush) begin
                    flushPend_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = ST_REFILL_DATA;
                end
            end

            ST_REFILL_DATA: begin
                if (flush) begin
                    flushPend_d = 1'b1;
                end
                if (mem_resp_valid) begin
                    ramWriteEn = 1'b1;
                    beat_d     = beat_q + 1'b1;
                    if (beat_q == reqWord) begin
                        resp_d = mem_resp_data;
                    end
                    if (beat_q == LAST_BEAT) begin
                        tagWrite = 1'b1;
                        validSet = !(flush || flushPend_q);
                        state_d  = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_data  = resp_q;
                cpu_req_ready  = 1'b1;
                if (cpu_req_valid) begin
                    reqAddr_d = cpu_req_addr;
                    state_d   = ST_LOOKUP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!reset_n) begin
            cpu_req_ready = 1'b0;
        end
    end

    // Control registers: FSM state, captured request, beat counter, response word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            reqAddr_q   <= '0;
            beat_q      <= '0;
            resp_q      <= '0;
            flushPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reqAddr_q   <= reqAddr_d;
            beat_q      <= beat_d;
            resp_q      <= resp_d;
            flushPend_q <= flushPend_d;
        end
    end

    // Tag and valid arrays; a flush clears every valid bit and beats any line fill.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (tagWrite) begin
                tag_q[reqIdx] <= reqTag;
            end
            if (flush) begin
                valid_q <= '0;
            end else if (validSet) begin
                valid_q[reqIdx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a 4-line x 4-word geometry. A memory
// responder returns word = address; a response scoreboard checks data, error
// flag and the exact response cycle, and a refill queue checks every line request.
module tb_icache_dm;

    localparam int ADDR_W = 32;
    localparam int LINES  = 4;
    localparam int WPL    = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cpu_req_valid;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic              cpu_req_ready;
    logic              cpu_resp_valid;
    logic [31:0]       cpu_resp_data;
    logic              cpu_resp_err;
    logic              flush;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          isMiss;
        int          expCyc;
        string       tag;
    } expResp_t;

    expResp_t    respQ[$];
    logic [31:0] memQ[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    int readyDelay  = 0;
    int beatGap     = 0;
    int beatsSent   = 0;
    int lastBeatCyc = 0;
    int memReqCount = 0;
    bit memBusy     = 1'b0;

    icache_dm #(
        .ADDR_W         (ADDR_W),
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_data  (cpu_resp_data),
        .cpu_resp_err   (cpu_resp_err),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one fetch request, wait for acceptance, and queue what should come back.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expData,
                                 input logic expErr, input bit isMiss, input bit expectResp,
                                 input string tag);
        expResp_t e;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        #1;
        for (int i = 0; i < 100 && cpu_req_ready !== 1'b1; i++) begin
            @(negedge clock);
            #1;
        end
        if (cpu_req_ready !== 1'b1) begin
            checkOutput({tag, "_ready_timeout"}, {31'd0, cpu_req_ready}, 32'd1);
        end else begin
            if (expectResp) begin
                e.data   = expData;
                e.err    = expErr;
                e.isMiss = isMiss;
                e.expCyc = cyc + 1;
                e.tag    = tag;
                respQ.push_back(e);
            end
            if (isMiss) begin
                memQ.push_back(addr & ~32'hF);
            end
        end
        @(negedge clock);
        cpu_req_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (respQ.size() == 0 && memQ.size() == 0 && !memBusy) break;
            @(negedge clock);
        end
        checkOutput({tag, "_pending"}, 32'(respQ.size() + memQ.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    // Response monitor: every pulse must match the oldest queued expectation.
    always begin
        expResp_t e;
        @(negedge clock);
        #2;
        if (reset_n === 1'b1 && cpu_resp_valid === 1'b1) begin
            if (respQ.size() == 0) begin
                checkOutput("resp_unexpected", {31'd0, cpu_resp_valid}, 32'd0);
            end else begin
                e = respQ.pop_front();
                checkOutput({e.tag, "_data"}, cpu_resp_data, e.data);
                checkOutput({e.tag, "_err"}, {31'd0, cpu_resp_err}, {31'd0, e.err});
                checkOutput({e.tag, "_cycle"}, 32'(cyc), 32'(e.isMiss ? lastBeatCyc : e.expCyc));
            end
        end
    end

    // Backing memory: accept a line request after readyDelay cycles, then stream four beats.
    initial begin
        logic [31:0] line;
        logic [31:0] expLine;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && mem_req_valid === 1'b1) begin
                memBusy   = 1'b1;
                beatsSent = 0;
                memReqCount++;
                line = mem_req_addr;
                if (memQ.size() == 0) begin
                    checkOutput("mem_req_unexpected", {31'd0, mem_req_valid}, 32'd0);
                end else begin
                    expLine = memQ.pop_front();
                    checkOutput("mem_req_addr", mem_req_addr, expLine);
                end
                for (int d = 0; d < readyDelay; d++) begin
                    @(negedge clock);
                    checkOutput("mem_req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
                    checkOutput("mem_req_hold_addr", mem_req_addr, line);
                end
                mem_req_ready = 1'b1;
                @(negedge clock);
                mem_req_ready = 1'b0;
                for (int b = 0; b < WPL; b++) begin
                    for (int g = 0; g < beatGap; g++) begin
                        mem_resp_valid = 1'b0;
                        @(negedge clock);
                    end
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = line + 32'(4 * b);
                    if (b == WPL - 1) lastBeatCyc = cyc + 1;
                    beatsSent = b + 1;
                    @(negedge clock);
                end
                mem_resp_valid = 1'b0;
                memBusy        = 1'b0;
            end
        end
    end

    // Safety net in case something stalls without tripping a bounded wait.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = 32'd0;
        flush         = 1'b0;
        #1;
        checkOutput("rst_req_ready", {31'd0, cpu_req_ready}, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, cpu_resp_err}, 32'd0);
        checkOutput("rst_resp_data", cpu_resp_data, 32'd0);
        checkOutput("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rst_mem_req_addr", mem_req_addr, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", {31'd0, cpu_req_ready}, 32'd1);
        @(negedge clock);

        // Cold miss, then a hit on the freshly filled line.
        applyStimulus(32'h8002_0008, 32'h8002_0008, 1'b0, 1'b1, 1'b1, "cold_miss");
        waitIdle("cold_miss");
        applyStimulus(32'h8002_000C, 32'h8002_000C, 1'b0, 1'b0, 1'b1, "hit_after_fill");
        waitIdle("hit_after_fill");

        // Back-to-back hits: one response per cycle.
        applyStimulus(32'h8002_0000, 32'h8002_0000, 1'b0, 1'b0, 1'b1, "b2b_0");
        applyStimulus(32'h8002_0004, 32'h8002_0004, 1'b0, 1'b0, 1'b1, "b2b_1");
        applyStimulus(32'h8002_0008, 32'h8002_0008, 1'b0, 1'b0, 1'b1, "b2b_2");
        waitIdle("b2b");

        // Conflict eviction on index 0, second refill with a slow memory.
        applyStimulus(32'h8002_0040, 32'h8002_0040, 1'b0, 1'b1, 1'b1, "conflict_new");
        waitIdle("conflict_new");
        readyDelay = 2;
        beatGap    = 1;
        applyStimulus(32'h8002_0000, 32'h8002_0000, 1'b0, 1'b1, 1'b1, "conflict_back");
        waitIdle("conflict_back");
        readyDelay = 0;
        beatGap    = 0;

        // Misaligned fetch: error, zero data, no refill.
        applyStimulus(32'h8002_0002, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "misaligned");
        waitIdle("misaligned");

        // Flush during a refill: word returned, line stays invalid.
        beatGap   = 1;
        beatsSent = 0;
        applyStimulus(32'h8002_0010, 32'h8002_0010, 1'b0, 1'b1, 1'b1, "flush_mid");
        for (int i = 0; i < 100; i++) begin
            if (memBusy && beatsSent >= 1) break;
            @(negedge clock);
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        waitIdle("flush_mid");
        beatGap = 0;
        applyStimulus(32'h8002_0010, 32'h8002_0010, 1'b0, 1'b1, 1'b1, "flush_refetch");
        waitIdle("flush_refetch");
        applyStimulus(32'h8002_0014, 32'h8002_0014, 1'b0, 1'b0, 1'b1, "flush_line_hit");
        waitIdle("flush_line_hit");
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        applyStimulus(32'h8002_0014, 32'h8002_0014, 1'b0, 1'b1, 1'b1, "flush_idle_miss");
        waitIdle("flush_idle_miss");

        // Reset in the middle of a refill: no response, lines invalidated.
        beatsSent = 0;
        applyStimulus(32'h8002_0020, 32'h0000_0000, 1'b0, 1'b1, 1'b0, "reset_abort");
        for (int i = 0; i < 100; i++) begin
            if (memBusy && beatsSent >= 2) break;
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("midrst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        checkOutput("midrst_req_ready", {31'd0, cpu_req_ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        waitIdle("reset_abort");
        applyStimulus(32'h8002_0000, 32'h8002_0000, 1'b0, 1'b1, 1'b1, "after_reset_miss");
        waitIdle("after_reset_miss");
        applyStimulus(32'h8002_0004, 32'h8002_0004, 1'b0, 1'b0, 1'b1, "after_reset_hit");
        waitIdle("after_reset_hit");

        checkOutput("mem_req_count", 32'(memReqCount), 32'd8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
